// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode encoding,
// handshake FSM states and the divide-by-zero result convention.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_XOR   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Quotient of x/0 is every bit set; remainder of x/0 is the dividend itself.
    localparam logic DIV0_QUO_BIT = 1'b1;

    function automatic logic is_muldiv(input alu_op_e op);
        logic r;
        case (op)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input alu_op_e op);
        logic r;
        case (op)
            OP_DIVU, OP_REMU: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo hold {product high, product low} or {remainder, quotient} when done.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opb_r;
    logic             div_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;
    logic             done_s;

    // One iteration step: multiply shifts the product right, divide shifts the remainder left.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_trial_s = {hi_r, lo_r[WIDTH-1]};
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        if (div_r) begin
            if (div_trial_s >= {1'b0, opb_r}) begin
                hi_nxt_s = WIDTH'(div_trial_s - {1'b0, opb_r});
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_trial_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[WIDTH:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
        done_s = busy_r && (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Operand load on start, then WIDTH iteration steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            opb_r  <= {WIDTH{1'b0}};
            div_r  <= 1'b0;
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= op_a;
            opb_r  <= op_b;
            div_r  <= div_sel;
            busy_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (busy_r) begin
            hi_r   <= hi_nxt_s;
            lo_r   <= lo_nxt_s;
            cnt_r  <= cnt_r + CNT_W'(1);
            busy_r <= !done_s;
        end else begin
            hi_r   <= hi_r;
            lo_r   <= lo_r;
        end
    end

    assign done = done_s;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops plus iterative MUL/DIV,
// with result and zero flag registered and held until accepted.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);

    state_e           state_r;
    state_e           state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    alu_op_e          op_r;

    alu_op_e          op_in_s;
    logic             accept_s;
    logic             start_s;
    logic             load_s;
    logic             release_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;
    logic [SH_W-1:0]  sh_s;
    logic [WIDTH-1:0] single_s;
    logic [WIDTH-1:0] final_s;

    assign op_in_s = alu_op_e'(bus.alu_op);
    assign sh_s    = b_r[SH_W-1:0];

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .div_sel (is_div(op_in_s)),
        .op_a    (bus.a),
        .op_b    (bus.b),
        .done    (md_done_s),
        .hi      (md_hi_s),
        .lo      (md_lo_s)
    );

    // Next-state and handshake control; DONE loads the result once, then waits for out_ready.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        start_s   = 1'b0;
        load_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    if (is_muldiv(op_in_s)) begin
                        start_s = 1'b1;
                        state_s = ST_ITER;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (md_done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ITER;
                end
            end
            ST_DONE: begin
                if (!out_valid_r) begin
                    load_s = 1'b1;
                end else if (bus.out_ready) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Single-cycle datapath on the captured operands.
    always_comb begin
        single_s = {WIDTH{1'b0}};
        case (op_r)
            OP_ADD:  single_s = a_r + b_r;
            OP_SUB:  single_s = a_r - b_r;
            OP_AND:  single_s = a_r & b_r;
            OP_OR:   single_s = a_r | b_r;
            OP_XOR:  single_s = a_r ^ b_r;
            OP_SLT:  single_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_SLTU: single_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
            OP_SLL:  single_s = a_r << sh_s;
            OP_SRL:  single_s = a_r >> sh_s;
            OP_SRA:  single_s = $unsigned($signed(a_r) >>> sh_s);
            default: single_s = {WIDTH{1'b0}};
        endcase
    end

    // Final result selection, including the divide-by-zero conventions.
    always_comb begin
        final_s = single_s;
        case (op_r)
            OP_MUL:   final_s = md_lo_s;
            OP_MULHU: final_s = md_hi_s;
            OP_DIVU:  final_s = (b_r == {WIDTH{1'b0}}) ? {WIDTH{DIV0_QUO_BIT}} : md_lo_s;
            OP_REMU:  final_s = (b_r == {WIDTH{1'b0}}) ? a_r : md_hi_s;
            default:  final_s = single_s;
        endcase
    end

    // FSM state and in_ready, which is high exactly while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ST_IDLE);
        end
    end

    // Operand capture on accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
            op_r <= OP_ADD;
        end else if (accept_s) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            op_r <= op_in_s;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Result/zero/out_valid registers, held until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            result_r    <= final_s;
            zero_r      <= (final_s == {WIDTH{1'b0}});
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: latency, results, zero flag,
// backpressure, back-to-back issue and mid-operation reset.
module tb_alu_seq;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op, wait for out_valid (bounded), sample, optionally accept it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit pop, output logic [31:0] res, output logic zr, output int lat);
        int cnt;
        @(negedge clk);
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0000_0003;
        bus.alu_op   = 4'd1;
        cnt = 0;
        while (!bus.out_valid && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        lat = bus.out_valid ? cnt : 1000;
        res = bus.result;
        zr  = bus.zero;
        if (pop) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_result got %h/%b want 00000000/1", bus.result, bus.zero);
        end
    endtask

    task automatic test_single();
        vec_t tbl [16];
        logic [31:0] res;
        logic zr;
        int lat;
        tbl[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        tbl[2]  = '{4'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
        tbl[3]  = '{4'd3,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
        tbl[4]  = '{4'd5,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0};
        tbl[5]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tbl[6]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[7]  = '{4'd4,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8]  = '{4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[9]  = '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        tbl[10] = '{4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        tbl[11] = '{4'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        tbl[12] = '{4'd9,  32'h4000_0000, 32'h0000_0024, 32'h0400_0000};
        tbl[13] = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        tbl[14] = '{4'd14, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
        tbl[15] = '{4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, res, zr, lat);
            vectors++;
            if (res !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL single_result[%0d] op=%0d got %h want %h", i, tbl[i].op, res, tbl[i].exp);
            end
            vectors++;
            if (zr !== (tbl[i].exp == 32'h0)) begin
                miscompares++;
                $display("FAIL single_zero[%0d] got %b want %b", i, zr, (tbl[i].exp == 32'h0));
            end
            vectors++;
            if (lat != 1) begin
                miscompares++;
                $display("FAIL single_latency[%0d] got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t tbl [12];
        logic [31:0] res;
        logic zr;
        int lat;
        tbl[0]  = '{4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        tbl[1]  = '{4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        tbl[2]  = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[3]  = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[4]  = '{4'd10, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        tbl[5]  = '{4'd12, 32'd100,       32'd7,         32'd14};
        tbl[6]  = '{4'd13, 32'd100,       32'd7,         32'd2};
        tbl[7]  = '{4'd12, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[8]  = '{4'd13, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009};
        tbl[9]  = '{4'd12, 32'd7,         32'd100,       32'd0};
        tbl[10] = '{4'd13, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};
        tbl[11] = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF};
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, res, zr, lat);
            vectors++;
            if (res !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL muldiv_result[%0d] op=%0d got %h want %h", i, tbl[i].op, res, tbl[i].exp);
            end
            vectors++;
            if (zr !== (tbl[i].exp == 32'h0)) begin
                miscompares++;
                $display("FAIL muldiv_zero[%0d] got %b want %b", i, zr, (tbl[i].exp == 32'h0));
            end
            vectors++;
            if (lat != 33) begin
                miscompares++;
                $display("FAIL muldiv_latency[%0d] got %0d want 33", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic zr;
        int lat;
        run_op(4'd0, 32'h0000_0002, 32'h0000_0003, 1'b0, res, zr, lat);
        vectors++;
        if (res !== 32'h5 || lat != 1) begin
            miscompares++;
            $display("FAIL bp_first got %h lat %0d want 00000005 lat 1", res, lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_op   = 4'd1;
            bus.a        = 32'h0000_0100 + 32'(i);
            bus.b        = 32'h0000_0001;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h5 || bus.zero !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%b r=%h z=%b want v=1 r=00000005 z=0",
                         i, bus.out_valid, bus.result, bus.zero);
            end
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_stale got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic zr;
        int lat;
        run_op(4'd0, 32'h0000_0010, 32'h0000_0020, 1'b1, res, zr, lat);
        vectors++;
        if (res !== 32'h30) begin
            miscompares++;
            $display("FAIL b2b_first got %h want 00000030", res);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready got %b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'd5;
        bus.a        = 32'hAAAA_5555;
        bus.b        = 32'hFFFF_0000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept got rdy=%b v=%b want rdy=0 v=0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL b2b_second got v=%b r=%h want v=1 r=55555555", bus.out_valid, bus.result);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_iter();
        logic [31:0] res;
        logic zr;
        int lat;
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'd12;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release got v=%b r=%h z=%b rdy=%b want 0/00000000/1/1",
                     bus.out_valid, bus.result, bus.zero, bus.in_ready);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_partial got %b want 0", bus.out_valid);
        end
        run_op(4'd13, 32'd100, 32'd7, 1'b1, res, zr, lat);
        vectors++;
        if (res !== 32'd2 || lat != 33) begin
            miscompares++;
            $display("FAIL rst_next_op got %h lat %0d want 00000002 lat 33", res, lat);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.alu_op    = 4'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_iter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
